ac_power_sequencer: RTL and testbench
=====================================

// Module: ac_power_sequencer
// PURPOSE
//  Consumer of the economy-mode close_ac request. Owns AC compressor enable:
//  debounces close_ac, shuts the AC down on a confirmed request, enforces a
//  compressor restart hold-off, and re-enables only when the user still requests AC.
//  Sits between ac_economy_mode and the AC power output of the home controller.
// PARAMETERS
//  CNT_W              16  width of the shared debounce/hold-off counter
//  CLOSE_DEBOUNCE_CYC 16  consecutive close_ac samples in PEND needed to shut down (>=1, <2^CNT_W)
//  RESTART_DELAY_CYC  64  cycles spent in HOLDOFF after any shutdown (>=1, <2^CNT_W)
// PORTS
//  clk_i              in   1  system clock, rising edge
//  rst_n_i            in   1  reset, asynchronous, active-low
//  ac_request_i       in   1  user/thermostat wants AC on (level)
//  close_ac_i         in   1  close request from economy mode (level)
//  ac_enable_o        out  1  AC compressor power enable
//  eco_block_o        out  1  AC held off because of an eco shutdown
//  ac_state_o         out  2  state code: OFF=00 RUN=01 PEND=10 HOLDOFF=11
//  eco_shutdown_cnt_o out  8  number of eco shutdowns, saturating
// BEHAVIOUR
//  - Reset (async assert, sync release): state OFF, counter 0, ac_enable_o=0,
//    eco_block_o=0, ac_state_o=00, eco_shutdown_cnt_o=0. Assert mid-operation
//    drops ac_enable_o immediately; no hold-off after reset release.
//  - All inputs sampled on rising clk_i; all outputs registered or decoded from
//    registers; no combinational input->output path.
//  - ac_enable_o = (state==RUN)|(state==PEND). ac_state_o = state register.
//  - OFF: ac_request_i & !close_ac_i -> RUN (enable high the cycle after the
//    sampling edge). Otherwise stay.
//  - RUN: !ac_request_i -> HOLDOFF (cnt<=0). Else close_ac_i -> PEND (cnt<=0).
//  - PEND: priority order per edge:
//    1) !ac_request_i -> HOLDOFF, cnt<=0, no eco event.
//    2) !close_ac_i -> RUN (glitch rejected, counter discarded).
//    3) cnt==CLOSE_DEBOUNCE_CYC-1 -> HOLDOFF, cnt<=0, eco event.
//    4) else cnt<=cnt+1.
//    => enable falls after CLOSE_DEBOUNCE_CYC+1 consecutive high samples of close_ac_i.
//  - HOLDOFF: inputs ignored for transitions; cnt==RESTART_DELAY_CYC-1 -> OFF,
//    else cnt<=cnt+1. HOLDOFF lasts exactly RESTART_DELAY_CYC cycles.
//  - Eco event: eco_block_o<=1; eco_shutdown_cnt_o<=cnt+1 unless already 8'hFF (holds 255).
//  - eco_block_o clears on the first edge where state is OFF or HOLDOFF and
//    (!close_ac_i | !ac_request_i); a set by an eco event wins over a clear in the same edge.
//  - Counter never wraps: it is cleared on every state entry and bounded by the
//    terminal compares above.
// STRUCTURE
//  - Single module, one always block for state+counter, one for outputs.
//  - State encodings (AC_ST_OFF/RUN/PEND/HOLDOFF) and default cycle counts go
//    in design_constant.vh next to the existing home constants.
//  - No sub-module; the close_ac debounce is folded into the FSM (PEND state).
// TESTING (bench params: CLOSE_DEBOUNCE_CYC=4, RESTART_DELAY_CYC=8)
//  1 reset, request=1, close=0 -> ac_enable_o=1 one cycle after first sampled edge, state=01.
//  2 in RUN, close=1 for 4 edges then 0 -> enable stays 1, state back to 01, cnt_o=0.
//  3 in RUN, close=1 held -> enable falls after 5th high edge, eco_block_o=1,
//    cnt_o=1, state=11 for exactly 8 cycles, then 00; with close still 1 stays 00.
//  4 after 3, close=0 while request=1 -> eco_block_o clears, RUN one edge after OFF.
//  5 request drops in PEND -> HOLDOFF, eco_block_o=0, cnt_o unchanged.
//  6 force 256 eco shutdowns -> cnt_o=255 and holds; rst_n_i low mid-HOLDOFF ->
//    all outputs 0 asynchronously, OFF->RUN one edge after release with request=1.

Source files
------------

// File: rtl/ac_power_sequencer_pkg.sv
// rtl/ac_power_sequencer_pkg.sv - state codes, default cycle counts and helpers for the AC power sequencer
package ac_power_sequencer_pkg;

    typedef enum logic [1:0] {
        AC_ST_OFF     = 2'b00,
        AC_ST_RUN     = 2'b01,
        AC_ST_PEND    = 2'b10,
        AC_ST_HOLDOFF = 2'b11
    } ac_state_e;

    localparam int AC_CNT_W_DEF           = 16;
    localparam int AC_CLOSE_DEBOUNCE_DEF  = 16;
    localparam int AC_RESTART_DELAY_DEF   = 64;

    localparam logic [7:0] AC_ECO_CNT_MAX = 8'hFF;

    // Eco shutdown count sticks at its maximum instead of wrapping.
    function automatic logic [7:0] ac_sat_inc8(input logic [7:0] value);
        return (value == AC_ECO_CNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/ac_power_sequencer.sv
// rtl/ac_power_sequencer.sv - AC compressor enable sequencer with close_ac debounce and restart hold-off
module ac_power_sequencer
    import ac_power_sequencer_pkg::*;
#(
    parameter int CNT_W              = AC_CNT_W_DEF,
    parameter int CLOSE_DEBOUNCE_CYC = AC_CLOSE_DEBOUNCE_DEF,
    parameter int RESTART_DELAY_CYC  = AC_RESTART_DELAY_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ac_request_i,
    input  logic       close_ac_i,
    output logic       ac_enable_o,
    output logic       eco_block_o,
    output logic [1:0] ac_state_o,
    output logic [7:0] eco_shutdown_cnt_o
);

    localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(CLOSE_DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LAST  = CNT_W'(RESTART_DELAY_CYC - 1);

    ac_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             eco_event;
    logic             eco_clear;

    // Confirmed close: request still present and close held through the whole debounce window.
    assign eco_event = (state_q == AC_ST_PEND) && ac_request_i && close_ac_i
                       && (cnt_q == DEBOUNCE_LAST);

    assign eco_clear = ((state_q == AC_ST_OFF) || (state_q == AC_ST_HOLDOFF))
                       && (!close_ac_i || !ac_request_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= AC_ST_OFF;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                AC_ST_OFF: begin
                    if (ac_request_i && !close_ac_i) begin
                        state_q <= AC_ST_RUN;
                        cnt_q   <= '0;
                    end
                end
                AC_ST_RUN: begin
                    if (!ac_request_i) begin
                        state_q <= AC_ST_HOLDOFF;
                        cnt_q   <= '0;
                    end else if (close_ac_i) begin
                        state_q <= AC_ST_PEND;
                        cnt_q   <= '0;
                    end
                end
                AC_ST_PEND: begin
                    if (!ac_request_i) begin
                        state_q <= AC_ST_HOLDOFF;
                        cnt_q   <= '0;
                    end else if (!close_ac_i) begin
                        state_q <= AC_ST_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEBOUNCE_LAST) begin
                        state_q <= AC_ST_HOLDOFF;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                AC_ST_HOLDOFF: begin
                    // Restart hold-off protects the compressor regardless of inputs.
                    if (cnt_q == HOLDOFF_LAST) begin
                        state_q <= AC_ST_OFF;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= AC_ST_OFF;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            eco_block_o        <= 1'b0;
            eco_shutdown_cnt_o <= 8'd0;
        end else begin
            if (eco_event) begin
                eco_block_o        <= 1'b1;
                eco_shutdown_cnt_o <= ac_sat_inc8(eco_shutdown_cnt_o);
            end else if (eco_clear) begin
                eco_block_o        <= 1'b0;
            end
        end
    end

    assign ac_enable_o = (state_q == AC_ST_RUN) || (state_q == AC_ST_PEND);
    assign ac_state_o  = state_q;

endmodule

// File: tb/tb_ac_power_sequencer.sv
// tb/tb_ac_power_sequencer.sv - randomized self-checking bench for ac_power_sequencer against a streak/countdown model
module tb_ac_power_sequencer;

    localparam int DEB = 4;
    localparam int RST = 8;

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       ac_request_i;
    logic       close_ac_i;
    logic       ac_enable_o;
    logic       eco_block_o;
    logic [1:0] ac_state_o;
    logic [7:0] eco_shutdown_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phase 0 = idle, 1 = powered, 2 = hold-off countdown.
    int m_phase;
    int m_streak;
    int m_remain;
    bit m_block;
    int m_cnt;

    ac_power_sequencer #(
        .CNT_W              (16),
        .CLOSE_DEBOUNCE_CYC (DEB),
        .RESTART_DELAY_CYC  (RST)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n_i),
        .ac_request_i       (ac_request_i),
        .close_ac_i         (close_ac_i),
        .ac_enable_o        (ac_enable_o),
        .eco_block_o        (eco_block_o),
        .ac_state_o         (ac_state_o),
        .eco_shutdown_cnt_o (eco_shutdown_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int m_code();
        if (m_phase == 0) return 0;
        if (m_phase == 2) return 3;
        return (m_streak > 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_streak = 0;
        m_remain = 0;
        m_block  = 0;
        m_cnt    = 0;
    endtask

    task automatic model_edge(input bit req, input bit close);
        bit idle_or_hold;
        bit eco;
        idle_or_hold = (m_phase != 1);
        eco = 0;
        case (m_phase)
            0: if (req && !close) begin
                m_phase  = 1;
                m_streak = 0;
            end
            1: begin
                if (!req) begin
                    m_phase  = 2;
                    m_remain = RST;
                end else if (close) begin
                    m_streak++;
                    if (m_streak == DEB + 1) begin
                        eco      = 1;
                        m_phase  = 2;
                        m_remain = RST;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            default: begin
                m_remain--;
                if (m_remain == 0) m_phase = 0;
            end
        endcase
        if (m_phase != 1) m_streak = 0;
        if (eco) begin
            m_block = 1;
            if (m_cnt < 255) m_cnt++;
        end else if (idle_or_hold && (!close || !req)) begin
            m_block = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_enable"}, int'(ac_enable_o), int'(m_phase == 1));
        check({tag, "_state"},  int'(ac_state_o), m_code());
        check({tag, "_block"},  int'(eco_block_o), int'(m_block));
        check({tag, "_ecocnt"}, int'(eco_shutdown_cnt_o), m_cnt);
    endtask

    task automatic step(input bit req, input bit close);
        ac_request_i = req;
        close_ac_i   = close;
        @(posedge clk);
        model_edge(req, close);
        #1;
        check_all("step");
    endtask

    task automatic eco_shutdown_cycle();
        step(1, 0);
        repeat (DEB + 1) step(1, 1);
        repeat (RST) step(1, 1);
    endtask

    initial begin
        bit req;
        bit close;
        rst_n_i      = 1'b0;
        ac_request_i = 1'b0;
        close_ac_i   = 1'b0;
        model_reset();
        #12;
        check("reset_enable", int'(ac_enable_o), 0);
        check("reset_state",  int'(ac_state_o), 0);
        check("reset_block",  int'(eco_block_o), 0);
        check("reset_ecocnt", int'(eco_shutdown_cnt_o), 0);
        rst_n_i = 1'b1;

        step(1, 0);
        check("t1_enable", int'(ac_enable_o), 1);
        check("t1_state",  int'(ac_state_o), 1);

        repeat (DEB) step(1, 1);
        step(1, 0);
        check("t2_state",  int'(ac_state_o), 1);
        check("t2_ecocnt", int'(eco_shutdown_cnt_o), 0);

        repeat (DEB) step(1, 1);
        check("t3_enable_before", int'(ac_enable_o), 1);
        step(1, 1);
        check("t3_enable_after", int'(ac_enable_o), 0);
        check("t3_block",        int'(eco_block_o), 1);
        check("t3_ecocnt",       int'(eco_shutdown_cnt_o), 1);
        for (int i = 0; i < RST - 1; i++) begin
            step(1, 1);
            check("t3_holdoff", int'(ac_state_o), 3);
        end
        step(1, 1);
        check("t3_off", int'(ac_state_o), 0);
        step(1, 1);
        check("t3_stay_off", int'(ac_state_o), 0);

        step(1, 0);
        check("t4_block", int'(eco_block_o), 0);
        check("t4_state", int'(ac_state_o), 1);

        step(1, 1);
        check("t5_pend", int'(ac_state_o), 2);
        step(0, 1);
        check("t5_state",  int'(ac_state_o), 3);
        check("t5_block",  int'(eco_block_o), 0);
        check("t5_ecocnt", int'(eco_shutdown_cnt_o), 1);
        repeat (RST) step(0, 0);

        req   = 1;
        close = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) req = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) close = $urandom_range(0, 1) != 0;
            step(req, close);
        end

        for (int i = 0; i < 2 * RST + 2 && m_phase != 0; i++) step(0, 0);
        check("sat_idle_reached", m_phase, 0);
        repeat (256) eco_shutdown_cycle();
        check("sat_255", int'(eco_shutdown_cnt_o), 255);
        eco_shutdown_cycle();
        check("sat_hold", int'(eco_shutdown_cnt_o), 255);

        step(1, 0);
        repeat (DEB + 1) step(1, 1);
        repeat (3) step(1, 1);
        check("t6_in_holdoff", int'(ac_state_o), 3);
        #3 rst_n_i = 1'b0;
        #1;
        model_reset();
        check("t6_async_enable", int'(ac_enable_o), 0);
        check("t6_async_state",  int'(ac_state_o), 0);
        check("t6_async_block",  int'(eco_block_o), 0);
        check("t6_async_ecocnt", int'(eco_shutdown_cnt_o), 0);
        #2 rst_n_i = 1'b1;
        step(1, 0);
        check("t6_run_enable", int'(ac_enable_o), 1);
        check("t6_run_state",  int'(ac_state_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
